decode_cycle: RTL and testbench
===============================

DECODE_CYCLE -- requirements
Module: decode_cycle

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have these ports (name / direction / width / meaning):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- InstrD  in  32  fetched instruction
- PCD  in  32  instruction address
- PCPlus4D  in  32  PCD+4
- RegWriteW  in  1  writeback write enable
- RDW  in  5  writeback destination
- ResultW  in  32  writeback data
- FlushE  in  1  insert bubble into E
- RegWriteE  out  1  registered control
- ResultSrcE  out  1  0=ALU result, 1=memory data
- MemWriteE  out  1  store enable
- BranchE  out  1  beq
- ALUSrcE  out  1  0=RD2, 1=ImmExt
- ALUControlE  out  3  ALU operation
- RD1E  out  32  registered read data
- RD2E  out  32  registered read data
- ImmExtE  out  32  registered extended immediate
- RS1E, RS2E, RDE  out  5 each  registered register indices
- PCE, PCPlus4E  out  32 each  registered PCs

Function
REQ-003 The register file SHALL hold 32x32-bit registers, written on the rising clk edge when RegWriteW=1 and RDW!=0.
REQ-004 Reads of x0 SHALL return 0; writes to x0 SHALL be ignored.
REQ-005 A read whose index equals RDW while RegWriteW=1 and RDW!=0 SHALL return ResultW in the same cycle (write-before-read bypass).
REQ-006 Decode SHALL produce the following controls: lw 0000011 -> RegWrite=1, ResultSrc=1, ALUSrc=1, add. sw 0100011 -> MemWrite=1, ALUSrc=1, add. R-type 0110011 -> RegWrite=1. I-ALU 0010011 -> RegWrite=1, ALUSrc=1. beq 1100011 -> Branch=1, sub.
REQ-007 ALUControl SHALL encode add=000, sub=001, and=010, or=011, slt=101.
REQ-008 For R-type/I-ALU, ALUControl SHALL be derived from funct3 and funct7[5]: 000 -> add, or sub when R-type and funct7[5]=1; 010 -> slt; 110 -> or; 111 -> and.
REQ-009 Unsupported opcodes or funct3 values SHALL decode to all controls 0 (NOP).
REQ-010 ImmExt SHALL be sign-extended from InstrD[31]: I = InstrD[31:20]; S = {InstrD[31:25], InstrD[11:7]}; B = {InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 0}.
REQ-011 All E outputs SHALL be registered with a latency of one cycle from the D inputs.
REQ-012 When FlushE=1 at a clk edge, all E outputs SHALL load 0, whatever InstrD is.
REQ-013 The register-file write and the E-register update SHALL occur on the same clk edge.

Reset
REQ-014 reset=1 at a clk edge SHALL clear every E output and all 32 registers to 0.
REQ-015 reset SHALL take priority over FlushE and over a simultaneous writeback.
REQ-016 After deassertion, the first edge SHALL capture D-stage data normally.

Structure
REQ-017 Opcode constants, ALUControl encodings and immediate-format codes SHALL reside in shared package riscv_pkg.
REQ-018 The register file SHALL be sub-module register_file: one write port and two combinational read ports with bypass.

Verification
REQ-019 Write x5=0xDEADBEEF via W (RegWriteW=1, RDW=5), then decode add x6,x5,x0 -> next cycle RD1E=0xDEADBEEF, RegWriteE=1, ALUControlE=000.
REQ-020 In the same cycle, RDW=7 with ResultW=0x12345678 and InstrD reading rs1=x7 -> RD1E=0x12345678 after one edge.
REQ-021 Write x0=0xFFFFFFFF, then read x0 -> RD1E=0.
REQ-022 sw with imm=-4 (InstrD=0xFE512E23) -> ImmExtE=0xFFFFFFFC, MemWriteE=1, ALUSrcE=1, RegWriteE=0.
REQ-023 beq with FlushE=1 -> all E outputs 0; the next beq without flush -> BranchE=1, ALUControlE=001.
REQ-024 Assert reset while x3 is being written -> x3 reads 0 and all E outputs are 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: opcodes, ALU operation codes, immediate
// formats and the bundle of decoded control signals.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } aluCtrl_t;

  typedef enum logic [1:0] {
    IMM_NONE = 2'b00,
    IMM_I    = 2'b01,
    IMM_S    = 2'b10,
    IMM_B    = 2'b11
  } immFmt_t;

  typedef struct packed {
    logic     regWrite;
    logic     resultSrc;
    logic     memWrite;
    logic     branch;
    logic     aluSrc;
    aluCtrl_t aluControl;
  } ctrl_t;

endpackage

// File: rtl/register_file.sv
// 32x32 register file with one write port, two combinational read ports and
// a write-before-read bypass so a same-cycle writeback is visible to decode.
module register_file
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        writeEn,
  input  logic [4:0]  writeAddr,
  input  logic [31:0] writeData,
  input  logic [4:0]  readAddr1,
  input  logic [4:0]  readAddr2,
  output logic [31:0] readData1,
  output logic [31:0] readData2
);

  logic [31:0] regs [32];
  logic        writeValid;

  assign writeValid = writeEn && (writeAddr != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (writeValid) begin
      regs[writeAddr] <= writeData;
    end
  end

  // x0 never matches the bypass because writeValid excludes it.
  always_comb begin
    readData1 = '0;
    readData2 = '0;
    if (writeValid && (readAddr1 == writeAddr)) readData1 = writeData;
    else if (readAddr1 != 5'd0)                 readData1 = regs[readAddr1];
    if (writeValid && (readAddr2 == writeAddr)) readData2 = writeData;
    else if (readAddr2 != 5'd0)                 readData2 = regs[readAddr2];
  end

endmodule

// File: rtl/decode_cycle.sv
// Decode stage: control decode, immediate extension, register read and the
// D->E pipeline register with flush.
module decode_cycle
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        RegWriteW,
  input  logic [4:0]  RDW,
  input  logic [31:0] ResultW,
  input  logic        FlushE,
  output logic        RegWriteE,
  output logic        ResultSrcE,
  output logic        MemWriteE,
  output logic        BranchE,
  output logic        ALUSrcE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [4:0]  RS1E,
  output logic [4:0]  RS2E,
  output logic [4:0]  RDE,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  ctrl_t       ctrlD;
  immFmt_t     immFmtD;
  logic [31:0] immExtD;
  logic [31:0] rd1D;
  logic [31:0] rd2D;

  assign opcode   = InstrD[6:0];
  assign funct3   = InstrD[14:12];
  assign funct7b5 = InstrD[30];

  register_file regFile (
    .clk       (clk),
    .reset     (reset),
    .writeEn   (RegWriteW),
    .writeAddr (RDW),
    .writeData (ResultW),
    .readAddr1 (InstrD[19:15]),
    .readAddr2 (InstrD[24:20]),
    .readData1 (rd1D),
    .readData2 (rd2D)
  );

  // Unsupported opcodes and ALU funct3 values fall back to an all-zero NOP.
  always_comb begin
    ctrlD   = '0;
    immFmtD = IMM_NONE;
    case (opcode)
      OP_LOAD: begin
        ctrlD.regWrite   = 1'b1;
        ctrlD.resultSrc  = 1'b1;
        ctrlD.aluSrc     = 1'b1;
        ctrlD.aluControl = ALU_ADD;
        immFmtD          = IMM_I;
      end
      OP_STORE: begin
        ctrlD.memWrite   = 1'b1;
        ctrlD.aluSrc     = 1'b1;
        ctrlD.aluControl = ALU_ADD;
        immFmtD          = IMM_S;
      end
      OP_BRANCH: begin
        ctrlD.branch     = 1'b1;
        ctrlD.aluControl = ALU_SUB;
        immFmtD          = IMM_B;
      end
      OP_RTYPE, OP_IALU: begin
        immFmtD        = (opcode == OP_IALU) ? IMM_I : IMM_NONE;
        ctrlD.regWrite = 1'b1;
        ctrlD.aluSrc   = (opcode == OP_IALU);
        case (funct3)
          3'b000:  ctrlD.aluControl = (opcode == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  ctrlD.aluControl = ALU_SLT;
          3'b110:  ctrlD.aluControl = ALU_OR;
          3'b111:  ctrlD.aluControl = ALU_AND;
          default: ctrlD            = '0;
        endcase
      end
      default: ctrlD = '0;
    endcase
  end

  always_comb begin
    immExtD = '0;
    case (immFmtD)
      IMM_I:   immExtD = {{20{InstrD[31]}}, InstrD[31:20]};
      IMM_S:   immExtD = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B:   immExtD = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      default: immExtD = '0;
    endcase
  end

  // Reset and flush both turn the E stage into a bubble; the register file
  // handles reset itself so a flush still lets the writeback land.
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      RegWriteE   <= 1'b0;
      ResultSrcE  <= 1'b0;
      MemWriteE   <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ALUControlE <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      RS1E        <= '0;
      RS2E        <= '0;
      RDE         <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
    end else begin
      RegWriteE   <= ctrlD.regWrite;
      ResultSrcE  <= ctrlD.resultSrc;
      MemWriteE   <= ctrlD.memWrite;
      BranchE     <= ctrlD.branch;
      ALUSrcE     <= ctrlD.aluSrc;
      ALUControlE <= ctrlD.aluControl;
      RD1E        <= rd1D;
      RD2E        <= rd2D;
      ImmExtE     <= immExtD;
      RS1E        <= InstrD[19:15];
      RS2E        <= InstrD[24:20];
      RDE         <= InstrD[11:7];
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
    end
  end

endmodule

// File: tb/tb_decode_cycle.sv
// Self-checking bench for decode_cycle: directed scenarios followed by random
// instructions, all compared against a mnemonic-level reference model.
module tb_decode_cycle;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        RegWriteW, FlushE;
  logic [4:0]  RDW;
  logic        RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  RS1E, RS2E, RDE;

  int total = 0;
  int bad   = 0;

  logic [31:0] refRegs [32];
  logic        expRegWrite, expResultSrc, expMemWrite, expBranch, expAluSrc;
  logic [2:0]  expAlu;
  logic [31:0] expRd1, expRd2, expImm, expPc, expPc4;
  logic [4:0]  expRs1, expRs2, expRd;
  bit          immKnown;

  decode_cycle dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .RS1E(RS1E), .RS2E(RS2E),
    .RDE(RDE), .PCE(PCE), .PCPlus4E(PCPlus4E)
  );

  always #5 clk = ~clk;

  function automatic string mnemonic(input logic [31:0] i);
    logic [6:0] op;
    op = i[6:0];
    if (op == 7'h03) return "lw";
    if (op == 7'h23) return "sw";
    if (op == 7'h63) return "beq";
    if (op == 7'h33 || op == 7'h13) begin
      case (i[14:12])
        3'd0:    return (op == 7'h33 && i[30]) ? "sub" : "add";
        3'd2:    return "slt";
        3'd6:    return "or";
        3'd7:    return "and";
        default: return "nop";
      endcase
    end
    return "nop";
  endfunction

  function automatic logic [31:0] readReg(input logic [4:0] idx, input logic we,
                                          input logic [4:0] wa, input logic [31:0] wd);
    if (idx == 5'd0) return 32'd0;
    if (we && wa == idx) return wd;
    return refRegs[idx];
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one D-stage cycle, predict the E stage, advance one edge.
  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                               input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic flush, input logic rst);
    string m;
    logic [6:0] op;
    @(negedge clk);
    InstrD = instr; PCD = pc; PCPlus4D = pc + 32'd4;
    RegWriteW = we; RDW = wa; ResultW = wd; FlushE = flush; reset = rst;
    m  = mnemonic(instr);
    op = instr[6:0];
    if (rst || flush) begin
      {expRegWrite, expResultSrc, expMemWrite, expBranch, expAluSrc} = '0;
      expAlu = '0; expRd1 = '0; expRd2 = '0; expImm = '0;
      expRs1 = '0; expRs2 = '0; expRd = '0; expPc = '0; expPc4 = '0;
      immKnown = 1'b1;
    end else begin
      expRegWrite  = (m == "lw" || m == "add" || m == "sub" || m == "slt" || m == "or" || m == "and");
      expResultSrc = (m == "lw");
      expMemWrite  = (m == "sw");
      expBranch    = (m == "beq");
      expAluSrc    = (m == "lw" || m == "sw" || (op == 7'h13 && m != "nop"));
      if (m == "sub" || m == "beq") expAlu = 3'd1;
      else if (m == "and")          expAlu = 3'd2;
      else if (m == "or")           expAlu = 3'd3;
      else if (m == "slt")          expAlu = 3'd5;
      else                          expAlu = 3'd0;
      expRs1 = instr[19:15]; expRs2 = instr[24:20]; expRd = instr[11:7];
      expRd1 = readReg(instr[19:15], we, wa, wd);
      expRd2 = readReg(instr[24:20], we, wa, wd);
      expPc = pc; expPc4 = pc + 32'd4;
      immKnown = 1'b1;
      if (op == 7'h03 || op == 7'h13) expImm = $signed(instr[31:20]);
      else if (op == 7'h23)           expImm = $signed({instr[31:25], instr[11:7]});
      else if (op == 7'h63)           expImm = $signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});
      else begin expImm = '0; immKnown = 1'b0; end
    end
    @(posedge clk);
    if (rst) for (int i = 0; i < 32; i++) refRegs[i] = '0;
    else if (we && wa != 5'd0) refRegs[wa] = wd;
    #1;
  endtask

  task automatic checkOutput();
    checkValue("RegWriteE", RegWriteE, expRegWrite);
    checkValue("ResultSrcE", ResultSrcE, expResultSrc);
    checkValue("MemWriteE", MemWriteE, expMemWrite);
    checkValue("BranchE", BranchE, expBranch);
    checkValue("ALUSrcE", ALUSrcE, expAluSrc);
    checkValue("ALUControlE", ALUControlE, expAlu);
    checkValue("RD1E", RD1E, expRd1);
    checkValue("RD2E", RD2E, expRd2);
    if (immKnown) checkValue("ImmExtE", ImmExtE, expImm);
    checkValue("RS1E", RS1E, expRs1);
    checkValue("RS2E", RS2E, expRs2);
    checkValue("RDE", RDE, expRd);
    checkValue("PCE", PCE, expPc);
    checkValue("PCPlus4E", PCPlus4E, expPc4);
  endtask

  initial begin
    logic [31:0] instr;
    logic [6:0]  ops [6];
    ops[0] = 7'h03; ops[1] = 7'h23; ops[2] = 7'h33;
    ops[3] = 7'h13; ops[4] = 7'h63; ops[5] = 7'h7F;
    for (int i = 0; i < 32; i++) refRegs[i] = '0;
    reset = 1'b1; InstrD = '0; PCD = '0; PCPlus4D = '0;
    RegWriteW = 1'b0; RDW = '0; ResultW = '0; FlushE = 1'b0;

    // Reset state
    applyStimulus(32'h00000013, 32'h100, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    applyStimulus(32'h00000013, 32'h100, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    checkOutput();
    checkValue("reset_RD1E", RD1E, 32'd0);

    // Write x5 then add x6,x5,x0
    applyStimulus(32'h00000013, 32'h104, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0);
    checkOutput();
    applyStimulus(32'h00028333, 32'h108, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    checkOutput();
    checkValue("add_RD1E", RD1E, 32'hDEADBEEF);
    checkValue("add_RegWriteE", RegWriteE, 1'b1);
    checkValue("add_ALUControlE", ALUControlE, 3'b000);

    // Same-cycle bypass of x7 into add x8,x7,x0
    applyStimulus(32'h00038433, 32'h10C, 1'b1, 5'd7, 32'h12345678, 1'b0, 1'b0);
    checkOutput();
    checkValue("bypass_RD1E", RD1E, 32'h12345678);

    // Writes to x0 are ignored, including by the bypass
    applyStimulus(32'h000004B3, 32'h110, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
    checkOutput();
    checkValue("x0_bypass_RD1E", RD1E, 32'd0);
    applyStimulus(32'h000004B3, 32'h114, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    checkOutput();
    checkValue("x0_RD1E", RD1E, 32'd0);

    // sw with imm=-4
    applyStimulus(32'hFE512E23, 32'h118, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    checkOutput();
    checkValue("sw_ImmExtE", ImmExtE, 32'hFFFFFFFC);
    checkValue("sw_MemWriteE", MemWriteE, 1'b1);
    checkValue("sw_ALUSrcE", ALUSrcE, 1'b1);
    checkValue("sw_RegWriteE", RegWriteE, 1'b0);

    // beq flushed, then beq unflushed
    applyStimulus(32'h00208463, 32'h11C, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    checkOutput();
    checkValue("flush_BranchE", BranchE, 1'b0);
    checkValue("flush_PCE", PCE, 32'd0);
    applyStimulus(32'h00208463, 32'h120, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    checkOutput();
    checkValue("beq_BranchE", BranchE, 1'b1);
    checkValue("beq_ALUControlE", ALUControlE, 3'b001);
    checkValue("beq_ImmExtE", ImmExtE, 32'd8);

    // Reset wins over a simultaneous write of x3
    applyStimulus(32'h00000013, 32'h124, 1'b1, 5'd3, 32'hAAAA5555, 1'b0, 1'b0);
    applyStimulus(32'h00018533, 32'h128, 1'b1, 5'd3, 32'h0BADF00D, 1'b1, 1'b1);
    checkOutput();
    applyStimulus(32'h00018533, 32'h12C, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    checkOutput();
    checkValue("reset_x3_RD1E", RD1E, 32'd0);
    checkValue("post_reset_PCE", PCE, 32'h12C);

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      instr = $urandom;
      instr[6:0] = ops[$urandom_range(0, 5)];
      if (instr[6:0] == 7'h03 || instr[6:0] == 7'h23) instr[14:12] = 3'b010;
      if (instr[6:0] == 7'h63) instr[14:12] = 3'b000;
      applyStimulus(instr, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                    $urandom, ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0));
      checkOutput();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
